// File: rtl/spi_rx_fifo_mmio.sv
// SPI receive FIFO with a picorv32 MMIO window (DATA/STATUS/CTRL/THRESH).
// Define SPI_RX_IRQ_EN to add the THRESH register and a level irq.
module spi_rx_fifo_mmio #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  spi_data,
  input  logic        spi_valid,
  input  logic        sel,
  input  logic        mem_valid,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;

  logic empty;
  logic full;
  logic acc;
  logic rd;
  logic wr;
  logic a_data;
  logic a_stat;
  logic a_ctrl;
  logic a_thr;
  logic pop;
  logic push;
  logic drop;
  logic flush;
  logic clr_ovf;
  logic we;
  logic [31:0] rd_val;
  logic [31:0] thr_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // mem_ready blocks a second accept while the ack is outstanding
  assign acc = sel & mem_valid & ~mem_ready;
  assign wr  = acc & (mem_wstrb != 4'd0);
  assign rd  = acc & (mem_wstrb == 4'd0);

  assign a_data = (mem_addr[3:2] == 2'd0);
  assign a_stat = (mem_addr[3:2] == 2'd1);
  assign a_ctrl = (mem_addr[3:2] == 2'd2);
  assign a_thr  = (mem_addr[3:2] == 2'd3);

  assign pop     = rd & a_data & ~empty;
  assign flush   = wr & a_ctrl & mem_wstrb[0] & mem_wdata[0];
  assign clr_ovf = wr & a_ctrl & mem_wstrb[0] & mem_wdata[1];
  assign push    = spi_valid & (~full | pop);
  assign drop    = spi_valid & full & ~pop;
  assign we      = push & ~flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push & ~pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop & ~push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // a dropped byte beats a same-cycle clear, a flush beats both
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop & ~flush) ovf_d = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      a_data: rd_val = empty ? 32'd0
                             : {23'd0, 1'b1, mem_q[rptr_q]};
      a_stat: rd_val = {16'd0, 8'(count_q), 5'd0,
                        ovf_q, full, empty};
      a_ctrl: rd_val = '0;
      a_thr:  rd_val = thr_rd;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (we) mem_q[wptr_q] <= spi_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      mem_ready <= acc;
      mem_rdata <= rd ? rd_val : 32'd0;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + AW'(1);
        if (pop)  rptr_q <= rptr_q + AW'(1);
      end
    end
  end

`ifdef SPI_RX_IRQ_EN
  logic [8:0] thresh_q;
  logic [8:0] thresh_d;
  logic       irq_d;
  logic       unused;

  assign unused = ^{mem_addr[1:0], mem_wdata[31:9]};
  assign thr_rd = {23'd0, thresh_q};

  always_comb begin
    thresh_d = thresh_q;
    if (wr & a_thr) begin
      if (mem_wstrb[0]) thresh_d[7:0] = mem_wdata[7:0];
      if (mem_wstrb[1]) thresh_d[8]   = mem_wdata[8];
    end
  end

  // irq follows the state that becomes visible at the same edge
  assign irq_d = ovf_d |
                 ((thresh_d != '0) &&
                  (10'(count_d) >= 10'(thresh_d)));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      thresh_q <= '0;
      irq      <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq      <= irq_d;
    end
  end
`else
  logic unused;

  assign unused = ^{mem_addr[1:0], mem_wdata[31:2]};
  assign thr_rd = '0;
  assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_fifo_mmio.sv
// Randomized bench for spi_rx_fifo_mmio against a queue-based model.
// Checks handshake timing, register map, overflow, flush and irq.
module tb_spi_rx_fifo_mmio;

  localparam int DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  spi_data;
  logic        spi_valid;
  logic        sel;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        irq;

  int nvec = 0;
  int nmis = 0;

  logic [7:0] q[$];
  logic       movf;
  logic [8:0] mthr;

  spi_rx_fifo_mmio #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .spi_data(spi_data), .spi_valid(spi_valid),
    .sel(sel), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .irq(irq)
  );

  always #5 clk_in = ~clk_in;

  function automatic void model_reset();
    q.delete();
    movf = 1'b0;
    mthr = '0;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else movf = 1'b1;
  endfunction

  function automatic logic [31:0] mstat();
    return {16'd0, 8'(q.size()), 5'd0, movf,
            q.size() == DEPTH, q.size() == 0};
  endfunction

  function automatic logic exp_irq();
`ifdef SPI_RX_IRQ_EN
    return movf || (mthr != 0 && q.size() >= int'(mthr));
`else
    return 1'b0;
`endif
  endfunction

  // pop happens before the push, so a full FIFO with a pop accepts the byte
  function automatic logic [31:0] model_access(
    input logic [3:0] a, input logic [31:0] wd,
    input logic [3:0] ws, input logic pv, input logic [7:0] pd);
    logic [31:0] r;
    logic [7:0]  h;
    logic        fl;
    r  = '0;
    fl = 1'b0;
    if (ws == 4'd0) begin
      case (a[3:2])
        2'd0: if (q.size() != 0) begin
          h = q.pop_front();
          r = {23'd0, 1'b1, h};
        end
        2'd1: r = mstat();
`ifdef SPI_RX_IRQ_EN
        2'd3: r = {23'd0, mthr};
`endif
        default: r = '0;
      endcase
    end else begin
      if (a[3:2] == 2'd2 && ws[0]) begin
        fl = wd[0];
        if (wd[1]) movf = 1'b0;
        if (fl) q.delete();
      end
`ifdef SPI_RX_IRQ_EN
      if (a[3:2] == 2'd3) begin
        if (ws[0]) mthr[7:0] = wd[7:0];
        if (ws[1]) mthr[8] = wd[8];
      end
`endif
    end
    if (pv && !fl) model_push(pd);
    return r;
  endfunction

  // one bus access; rdy = {after-ack, ack, pre-accept} ready samples
  task automatic bus(input logic [3:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input logic pv,
                     input logic [7:0] pd,
                     output logic [31:0] rd, output logic [2:0] rdy,
                     output logic [31:0] rd_after, output logic irq_a,
                     output logic [31:0] exp, output logic exp_i);
    @(negedge clk_in);
    sel = 1'b1; mem_valid = 1'b1; mem_addr = a;
    mem_wdata = wd; mem_wstrb = ws;
    spi_valid = pv; spi_data = pd;
    #1 rdy[0] = mem_ready;
    exp = model_access(a, wd, ws, pv, pd);
    exp_i = exp_irq();
    @(posedge clk_in); #1;
    spi_valid = 1'b0;
    rdy[1] = mem_ready;
    rd = mem_rdata;
    irq_a = irq;
    @(posedge clk_in); #1;
    rdy[2] = mem_ready;
    rd_after = mem_rdata;
    sel = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'd0;
  endtask

  task automatic push(input logic [7:0] b, output logic irq_o,
                      output logic exp_i);
    @(negedge clk_in);
    spi_valid = 1'b1; spi_data = b;
    model_push(b);
    exp_i = exp_irq();
    @(posedge clk_in); #1;
    spi_valid = 1'b0;
    irq_o = irq;
  endtask

  task automatic test_reset();
    logic [31:0] rd, ra, ex;
    logic [2:0]  rdy;
    logic        ia, ei;
    rst_in = 1'b0;
    spi_valid = 0; spi_data = 0; sel = 0; mem_valid = 0;
    mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
    model_reset();
    repeat (3) @(negedge clk_in);
    nvec++;
    if ({mem_ready, mem_rdata, irq} !== 34'd0) begin
      nmis++;
      $display("FAIL reset_outs: got %b/%h/%b want 0/0/0",
               mem_ready, mem_rdata, irq);
    end
    rst_in = 1'b1;
    bus(4'h4, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (rd !== ex || rd !== 32'h1) begin
      nmis++;
      $display("FAIL reset_status: got %h want %h", rd, ex);
    end
    nvec++;
    if (rdy !== 3'b010 || ra !== 32'd0) begin
      nmis++;
      $display("FAIL handshake: got %b/%h want 010/0", rdy, ra);
    end
    @(negedge clk_in);
    sel = 1'b1; mem_valid = 1'b1; mem_addr = 4'h4;
    @(posedge clk_in); #2;
    rst_in = 1'b0;
    #1;
    nvec++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'd0) begin
      nmis++;
      $display("FAIL async_reset: got %b/%h want 0/0",
               mem_ready, mem_rdata);
    end
    sel = 1'b0; mem_valid = 1'b0;
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_push_pop();
    logic [31:0] rd, ra, ex;
    logic [2:0]  rdy;
    logic        ia, ei, io;
    logic [3:0]  seq [7];
    seq = '{4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h4};
    push(8'hA5, io, ei);
    push(8'h3C, io, ei);
    for (int i = 0; i < 7; i++) begin
      bus(seq[i], 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
      nvec++;
      if (rd !== ex) begin
        nmis++;
        $display("FAIL push_pop[%0d]: got %h want %h", i, rd, ex);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd, ra, ex;
    logic [2:0]  rdy;
    logic        ia, ei, io;
    for (int i = 0; i <= DEPTH; i++) push(8'(i), io, ei);
    bus(4'h4, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (rd !== ex || rd !== 32'h1006) begin
      nmis++;
      $display("FAIL ovf_status: got %h want %h", rd, ex);
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus(4'h0, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
      nvec++;
      if (rd !== ex) begin
        nmis++;
        $display("FAIL ovf_drain[%0d]: got %h want %h", i, rd, ex);
      end
    end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] rd, ra, ex;
    logic [2:0]  rdy;
    logic        ia, ei, io;
    bus(4'h8, 32'h2, 4'h1, 0, 0, rd, rdy, ra, ia, ex, ei);
    for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i), io, ei);
    bus(4'h0, 0, 4'd0, 1, 8'h77, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (rd !== ex) begin
      nmis++;
      $display("FAIL fullpop_head: got %h want %h", rd, ex);
    end
    bus(4'h4, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (rd !== ex || rd !== 32'h1002) begin
      nmis++;
      $display("FAIL fullpop_status: got %h want %h", rd, ex);
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus(4'h0, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
      nvec++;
      if (rd !== ex) begin
        nmis++;
        $display("FAIL fullpop_drain[%0d]: got %h want %h",
                 i, rd, ex);
      end
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd, ra, ex;
    logic [2:0]  rdy;
    logic        ia, ei, io;
    for (int i = 0; i <= DEPTH; i++) push(8'($urandom), io, ei);
    for (int i = 0; i < DEPTH - 5; i++)
      bus(4'h0, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
    bus(4'h4, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (rd !== ex) begin
      nmis++;
      $display("FAIL ctrl_pre: got %h want %h", rd, ex);
    end
    bus(4'h8, 32'h3, 4'h1, 0, 0, rd, rdy, ra, ia, ex, ei);
    bus(4'h4, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (rd !== ex || rd !== 32'h1) begin
      nmis++;
      $display("FAIL ctrl_clear: got %h want %h", rd, ex);
    end
    for (int i = 0; i < 3; i++) push(8'(i), io, ei);
    bus(4'h8, 32'h1, 4'h1, 1, 8'h99, rd, rdy, ra, ia, ex, ei);
    bus(4'h4, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (rd !== ex) begin
      nmis++;
      $display("FAIL flush_push: got %h want %h", rd, ex);
    end
    for (int i = 0; i < DEPTH; i++) push(8'(i), io, ei);
    bus(4'h8, 32'h2, 4'h1, 1, 8'h55, rd, rdy, ra, ia, ex, ei);
    bus(4'h4, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (rd !== ex) begin
      nmis++;
      $display("FAIL clr_vs_ovf: got %h want %h", rd, ex);
    end
    bus(4'h8, 32'h3, 4'h1, 0, 0, rd, rdy, ra, ia, ex, ei);
    bus(4'h0, 0, 4'd0, 1, 8'h5A, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (rd !== ex) begin
      nmis++;
      $display("FAIL empty_rd_push: got %h want %h", rd, ex);
    end
    bus(4'h4, 32'hFFFF, 4'hF, 0, 0, rd, rdy, ra, ia, ex, ei);
    bus(4'h8, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (rd !== ex) begin
      nmis++;
      $display("FAIL ctrl_read: got %h want %h", rd, ex);
    end
    bus(4'h4, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (rd !== ex) begin
      nmis++;
      $display("FAIL one_entry: got %h want %h", rd, ex);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd, ra, ex;
    logic [2:0]  rdy;
    logic        ia, ei, io;
    bus(4'h8, 32'h3, 4'h1, 0, 0, rd, rdy, ra, ia, ex, ei);
    bus(4'hC, 32'h4, 4'h3, 0, 0, rd, rdy, ra, ia, ex, ei);
    bus(4'hC, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (rd !== ex) begin
      nmis++;
      $display("FAIL thresh_rd: got %h want %h", rd, ex);
    end
    for (int i = 0; i < 4; i++) begin
      push(8'(i), io, ei);
      nvec++;
      if (io !== ei) begin
        nmis++;
        $display("FAIL irq_push[%0d]: got %b want %b", i, io, ei);
      end
    end
    bus(4'h0, 0, 4'd0, 0, 0, rd, rdy, ra, ia, ex, ei);
    nvec++;
    if (ia !== ei) begin
      nmis++;
      $display("FAIL irq_pop: got %b want %b", ia, ei);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, ra, ex, wd;
    logic [2:0]  rdy;
    logic [3:0]  a, ws;
    logic        ia, ei, io;
    int          r;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        push(8'($urandom), io, ei);
        nvec++;
        if (io !== ei) begin
          nmis++;
          $display("FAIL rnd_irq_push[%0d]: got %b want %b",
                   i, io, ei);
        end
      end else begin
        r = $urandom_range(0, 9);
        a = (r < 6) ? 4'h0 : (r < 8) ? 4'h4 : (r < 9) ? 4'h8 : 4'hC;
        ws = ($urandom_range(0, 3) == 0) ? 4'(($urandom_range(1, 15)))
                                         : 4'd0;
        wd = ($urandom_range(0, 2) == 0) ? 32'($urandom)
                                         : 32'($urandom_range(0, 7));
        bus(a, wd, ws, 1'($urandom_range(0, 1)), 8'($urandom),
            rd, rdy, ra, ia, ex, ei);
        nvec++;
        if (rd !== ex || rdy !== 3'b010 || ra !== 32'd0 ||
            ia !== ei) begin
          nmis++;
          $display("FAIL rnd_bus[%0d]: got %h/%b/%h/%b want %h/010/0/%b",
                   i, rd, rdy, ra, ia, ex, ei);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_full_pop_push();
    test_ctrl();
    test_irq();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
